// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I(+M) control unit:
// opcodes, ALU codes, datapath select values, FSM states, instruction classes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RD_ALU  = 2'b00;
  localparam logic [1:0] RD_LOAD = 2'b01;
  localparam logic [1:0] RD_PC4  = 2'b10;
  localparam logic [1:0] RD_MD   = 2'b11;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MDWAIT = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_MD
  } iclass_e;

  function automatic iclass_e classify(
    input logic [6:0] op,
    input logic [6:0] f7
  );
    iclass_e c;
    case (op)
      OP_R:      c = (f7 == F7_MULDIV) ? C_MD : C_R;
      OP_I:      c = C_I;
      OP_LOAD:   c = C_LOAD;
      OP_STORE:  c = C_STORE;
      OP_BRANCH: c = C_BRANCH;
      OP_JAL:    c = C_JAL;
      OP_JALR:   c = C_JALR;
      OP_LUI:    c = C_LUI;
      OP_AUIPC:  c = C_AUIPC;
      default:   c = C_NONE;
    endcase
    return c;
  endfunction

  // fun3 -> ALU op for the register/immediate arithmetic group;
  // 101 maps to the logical shift, the caller upgrades it to SRA.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] a;
    case (f3)
      3'b000:  a = ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// Combinational (class, fun3, fun7) -> ALU operation and legality flag.
// Ports: cls, fun3, fun7 in; alu_control, legal out.
module alu_op_decoder
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int ALU_CTRL_W = 4
) (
  input  iclass_e               cls,
  input  logic [2:0]            fun3,
  input  logic [6:0]            fun7,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  legal
);

  logic [3:0] code;

  always_comb begin
    code  = ALU_ADD;
    legal = 1'b0;
    case (cls)
      C_R: begin
        code  = alu_base(fun3);
        legal = (fun7 == F7_ZERO);
        if (fun7 == F7_ALT) begin
          if (fun3 == 3'b000) begin
            code  = ALU_SUB;
            legal = 1'b1;
          end else if (fun3 == 3'b101) begin
            code  = ALU_SRA;
            legal = 1'b1;
          end
        end
      end
      C_I: begin
        code  = alu_base(fun3);
        legal = 1'b1;
        // only the shift-immediates reuse fun7 as a qualifier
        if (fun3 == 3'b001) begin
          legal = (fun7 == F7_ZERO);
        end else if (fun3 == 3'b101) begin
          legal = (fun7 == F7_ZERO) || (fun7 == F7_ALT);
          if (fun7 == F7_ALT) code = ALU_SRA;
        end
      end
      C_LOAD:   legal = (fun3 != 3'b011) && (fun3 < 3'b110);
      C_STORE:  legal = (fun3 < 3'b011);
      C_BRANCH: legal = (fun3 != 3'b010) && (fun3 != 3'b011);
      C_JALR:   legal = (fun3 == 3'b000);
      C_JAL:    legal = 1'b1;
      C_LUI:    legal = 1'b1;
      C_AUIPC:  legal = 1'b1;
      C_MD:     legal = ENABLE_M;
      default:  legal = 1'b0;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I(+M) control FSM: FETCH/DECODE/EXEC/(MDWAIT|MEM)/WB.
// Ports: clk, rst, IR fields, mem_ready, branch_taken, md_done in; datapath strobes/selects out.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            fun3,
  input  logic [6:0]            fun7,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  input  logic                  md_done,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_sel_data,
  output logic                  reg_write,
  output logic [1:0]            operand_a,
  output logic                  operand_b,
  output logic [2:0]            imm_sel,
  output logic [1:0]            rd_sel,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  md_start,
  output logic [2:0]            md_op,
  output logic                  illegal
);

  logic [2:0]            state;
  logic [2:0]            state_nx;
  iclass_e               cls;
  logic                  legal;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic                  is_jump;
  logic                  dp_active;

  // IR is stable from DECODE until the next fetch, so the class is
  // re-derived every cycle instead of being latched.
  assign cls     = classify(opcode, fun7);
  assign is_jump = (cls == C_JAL) || (cls == C_JALR);

  alu_op_decoder #(
    .ENABLE_M   (ENABLE_M),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_dec (
    .cls         (cls),
    .fun3        (fun3),
    .fun7        (fun7),
    .alu_control (dec_alu),
    .legal       (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_nx = S_MEM;
          C_BRANCH:        state_nx = S_FETCH;
          C_MD:            state_nx = S_MDWAIT;
          default:         state_nx = S_WB;
        endcase
      end
      S_MDWAIT: if (md_done) state_nx = S_WB;
      S_MEM: begin
        if (mem_ready) begin
          state_nx = (cls == C_STORE) ? S_FETCH : S_WB;
        end
      end
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ALU operand/immediate selects stay valid through EXEC, MEM and WB so
  // the shared ALU keeps producing the address or jump target.
  assign dp_active = (state == S_EXEC) || (state == S_MEM) ||
                     (state == S_WB);

  always_comb begin
    operand_a   = OPA_RS1;
    operand_b   = 1'b0;
    imm_sel     = IMM_I;
    alu_control = '0;
    if (state == S_FETCH) begin
      operand_a = OPA_PC;
    end else if (dp_active) begin
      alu_control = dec_alu;
      case (cls)
        C_I, C_LOAD, C_JALR: operand_b = 1'b1;
        C_STORE: begin
          operand_b = 1'b1;
          imm_sel   = IMM_S;
        end
        C_BRANCH: begin
          operand_a = OPA_PC;
          operand_b = 1'b1;
          imm_sel   = IMM_B;
        end
        C_JAL: begin
          operand_a = OPA_PC;
          operand_b = 1'b1;
          imm_sel   = IMM_J;
        end
        C_LUI: begin
          operand_a = OPA_ZERO;
          operand_b = 1'b1;
          imm_sel   = IMM_U;
        end
        C_AUIPC: begin
          operand_a = OPA_PC;
          operand_b = 1'b1;
          imm_sel   = IMM_U;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    reg_write    = 1'b0;
    rd_sel       = RD_ALU;
    md_start     = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        pc_write = (cls == C_BRANCH) && branch_taken;
        md_start = (cls == C_MD);
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (cls == C_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = is_jump;
        case (cls)
          C_LOAD:        rd_sel = RD_LOAD;
          C_JAL, C_JALR: rd_sel = RD_PC4;
          C_MD:          rd_sel = RD_MD;
          default:       rd_sel = RD_ALU;
        endcase
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign md_op = md_start ? fun3 : 3'b000;

endmodule
